// File: rtl/iob_timer_alarm.sv
// iob_timer_alarm: compare/alarm stage on the timer count with periodic re-arm and overrun tracking
module iob_timer_alarm #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int OVR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [2*DATA_W-1:0]   time_in,
  output logic                  irq
);
  localparam int TW = 2 * DATA_W;
  logic              en, periodic, irq_en, pending;
  logic [OVR_W-1:0]  ovr;
  logic [DATA_W-1:0] stage, rd_mux;
  logic [TW-1:0]     cmp, period;
  logic [7:0]        we;
  logic              hit, reload, clr_pend, clr_ovr, ovr_inc;
  assign irq = pending & irq_en;
  // Write decode, match detection and event arbitration terms
  always_comb begin
    for (int i = 0; i < 8; i++) we[i] = valid && |wstrb && (address == ADDR_W'(i));
    hit      = en && (time_in >= cmp);
    reload   = periodic && |period;
    clr_pend = we[1] && wdata[0];
    clr_ovr  = we[1] && wdata[1];
    ovr_inc  = hit && pending && !clr_pend;
  end
  // Read-data mux; unused bits and unmapped words return zero
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_W'(0): rd_mux = DATA_W'({irq_en, periodic, en});
      ADDR_W'(1): rd_mux = DATA_W'({ovr, 7'b0, pending});
      ADDR_W'(2): rd_mux = stage;
      ADDR_W'(3): rd_mux = cmp[TW-1:DATA_W];
      ADDR_W'(4): rd_mux = period[DATA_W-1:0];
      ADDR_W'(5): rd_mux = period[TW-1:DATA_W];
      ADDR_W'(6): rd_mux = cmp[DATA_W-1:0];
      ADDR_W'(7): rd_mux = cmp[TW-1:DATA_W];
      default:    rd_mux = '0;
    endcase
  end
  // Bus response: one-cycle acknowledge with registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      rdata <= valid ? rd_mux : '0;
    end
  end
  // Control and status: software writes take priority over hit side effects, except a hit keeps PENDING set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      pending  <= 1'b0;
      ovr      <= '0;
    end else begin
      if (we[0]) {irq_en, periodic, en} <= wdata[2:0];
      else if (hit && !reload) en <= 1'b0;
      if (hit) pending <= 1'b1;
      else if (clr_pend) pending <= 1'b0;
      if (clr_ovr) ovr <= OVR_W'(ovr_inc);
      else if (ovr_inc && ovr != '1) ovr <= ovr + OVR_W'(1);
    end
  end
  // Compare staging, atomic commit, periodic reload and period registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage  <= '0;
      cmp    <= '0;
      period <= '0;
    end else begin
      if (we[2]) stage <= wdata;
      if (we[3]) cmp <= {wdata, stage};
      else if (hit && reload) cmp <= cmp + period;
      if (we[4]) period[DATA_W-1:0] <= wdata;
      if (we[5]) period[TW-1:DATA_W] <= wdata;
    end
  end
endmodule

// File: doc/iob_timer_alarm.md
Name: iob_timer_alarm

Overview:
- Compare/alarm stage that sits directly downstream of the timer core.
- Consumes the timer's free-running 2*DATA_W time count.
- Raises a pending flag and interrupt when the count reaches a software-programmed compare value. Optionally re-arms itself periodically.
- Software access is through the same CPU native slave interface as the timer.

Parameters:
DATA_W, 32, CPU data word width; time count is 2*DATA_W
ADDR_W, 3, word address width of the register map (8 words)
OVR_W, 8, width of the saturating overrun counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
valid  input  1  CPU request valid
address  input  ADDR_W  word address
wdata  input  DATA_W  write data
wstrb  input  DATA_W/8  write strobes; any nonzero = full-word write, zero = read
rdata  output  DATA_W  read data, valid while ready=1
ready  output  1  request acknowledge
time_in  input  2*DATA_W  timer count (time_counter output of the timer)
irq  output  1  level interrupt = PENDING & IRQ_EN

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: all registers 0, rdata=0, ready=0, irq=0, staged compare=0.
- Handshake: ready registered, asserted the cycle after valid (1-cycle latency). Back-to-back requests are allowed.
- rdata is registered from the addressed register at the same edge as ready. Unmapped or unused bits read 0.
- Register map (word address):
  0 CTRL rw: b0 EN, b1 PERIODIC, b2 IRQ_EN.
  1 STATUS: b0 PENDING (write 1 clears); b[8+OVR_W-1:8] OVERRUN (read-only); write b1=1 clears OVERRUN.
  2 CMP_LOW: write stages low word only, not active; reads back the staged value.
  3 CMP_HIGH: write commits {wdata, staged low} atomically to the active compare CMP. Reads CMP[2*DATA_W-1:DATA_W].
  4 PERIOD_LOW, 5 PERIOD_HIGH: rw, take effect immediately.
  6 NEXT_LOW, 7 NEXT_HIGH: read-only view of the active CMP.
- Match: hit = EN & (time_in >= CMP), unsigned 2*DATA_W compare, evaluated at every edge.
  - On hit, PENDING is set at that edge; irq is visible the next cycle. Match-to-irq latency is 1 cycle.
- Re-arm on hit:
  - PERIODIC=1 and PERIOD!=0: CMP <= CMP + PERIOD, modulo 2^(2*DATA_W); wrap discarded. EN stays 1.
  - Otherwise (one-shot, or PERIOD=0): EN <= 0.
- Catch-up: if the reloaded CMP is still <= time_in, hit again on the next edge. Each such hit sets PENDING, reloads, and counts as overrun. There is no skip-ahead.
- Overrun: hit while PENDING already 1 → OVERRUN++, saturating at 2^OVR_W-1.
- Simultaneous events:
  - SW clear of PENDING + hit in same cycle: PENDING stays 1, OVERRUN unchanged.
  - SW write of CMP_HIGH + hit reload in same cycle: SW commit wins.
  - SW write of CTRL + hit in same cycle: SW value wins for EN.
  - SW clear of OVERRUN + hit with PENDING=1: OVERRUN becomes 1.
- Writing EN=1 with CMP <= time_in fires on the next edge.
- time_in wrap (timer reset to 0): no special handling. Alarm fires when the count again reaches CMP.
- rst_n low mid-operation: immediate return to reset values, irq drops asynchronously.

Test Plan:
- Reset/readback: assert rst_n=0 mid-transaction → ready=0, irq=0. After release, all 8 registers read 0, each with ready exactly 1 cycle after valid.
- One-shot: CMP=100, CTRL=0b101, time_in ramps from 90 → PENDING and irq rise the cycle after time_in=100. EN reads 0. Write STATUS=1 → irq=0, and there is no re-fire at time_in=200.
- Periodic: CMP=100, PERIOD=50, CTRL=0b111 → hits at 100, 150, 200. NEXT reads 250 after the third hit. OVERRUN increments 0→1→2 if PENDING is never cleared.
- Atomic compare and wrap: CMP_LOW=0xFFFF_FFF0, CMP_HIGH=0xFFFF_FFFF, PERIOD=0x20, periodic hit → NEXT = 0x0000_0000_0000_0010 (wrap). A CMP_LOW write alone leaves NEXT unchanged.
- Simultaneous: SW writes STATUS=1 on the same edge as a hit → PENDING=1, OVERRUN unchanged. CMP_HIGH write on the reload edge → NEXT equals the SW value.
- Catch-up and saturation: PERIOD=1, CMP=0, time_in held at 1000, PENDING never cleared → a hit fires every cycle and OVERRUN saturates at 255.
